// File: rtl/alu_muldiv_pkg.sv
// Shared types and constants for the ALU / iterative mul-div execution unit.
package alu_muldiv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ITER_CNT = 32;
    localparam int unsigned ROB_W    = 4;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned CNT_W    = 6;

    // Base funct3 encodings
    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SLL  = 3'b001;
    localparam logic [OP_W-1:0] OP_SLT  = 3'b010;
    localparam logic [OP_W-1:0] OP_SLTU = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_SR   = 3'b101;
    localparam logic [OP_W-1:0] OP_OR   = 3'b110;
    localparam logic [OP_W-1:0] OP_AND  = 3'b111;

    // RV32M funct3 encodings
    localparam logic [OP_W-1:0] OP_MUL    = 3'b000;
    localparam logic [OP_W-1:0] OP_MULH   = 3'b001;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'b010;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'b011;
    localparam logic [OP_W-1:0] OP_DIV    = 3'b100;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'b101;
    localparam logic [OP_W-1:0] OP_REM    = 3'b110;
    localparam logic [OP_W-1:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] opr1;
        logic [XLEN-1:0] opr2;
    } md_req_t;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic neg);
        return neg ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Issue bus from the reservation station and result broadcast bus.
interface alu_muldiv_if;
    import alu_muldiv_pkg::*;

    logic             rs2alu_ready;
    logic [OP_W-1:0]  rs2alu_op_L1;
    logic             rs2alu_op_L2;
    logic             rs2alu_mext;
    logic [XLEN-1:0]  rs2alu_opr1;
    logic [XLEN-1:0]  rs2alu_opr2;
    logic [ROB_W-1:0] rs2alu_rob_id;

    logic             alu_valid;
    logic [XLEN-1:0]  alu_value;
    logic [ROB_W-1:0] alu_dependency;
    logic             alu_busy_out;

    modport master (
        output rs2alu_ready, rs2alu_op_L1, rs2alu_op_L2, rs2alu_mext,
               rs2alu_opr1, rs2alu_opr2, rs2alu_rob_id,
        input  alu_valid, alu_value, alu_dependency, alu_busy_out
    );

    modport slave (
        input  rs2alu_ready, rs2alu_op_L1, rs2alu_op_L2, rs2alu_mext,
               rs2alu_opr1, rs2alu_opr2, rs2alu_rob_id,
        output alu_valid, alu_value, alu_dependency, alu_busy_out
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M engine: shift/add multiplier and restoring divider on magnitudes.
module alu_muldiv_iter
    import alu_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            flush,
    input  logic            start,
    input  md_req_t         req,
    output logic            busy,
    output logic            done_c,
    output logic [XLEN-1:0] result_c
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;

    logic              signed_a, signed_b, req_neg_a, req_neg_b;
    logic [XLEN-1:0]   req_abs_a, req_abs_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_part;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem_nx;
    logic              last_step;

    // Operand signedness by funct3: DIV/REM signed on op[0]=0; MULHSU has unsigned opr2
    always_comb begin
        signed_a  = req.op[2] ? ~req.op[0] : (req.op[1:0] != 2'b11);
        signed_b  = req.op[2] ? ~req.op[0] : ~req.op[1];
        req_neg_a = signed_a & req.opr1[XLEN-1];
        req_neg_b = signed_b & req.opr2[XLEN-1];
        req_abs_a = abs_val(req.opr1, req_neg_a);
        req_abs_b = abs_val(req.opr2, req_neg_b);
    end

    // acc holds {partial, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_part   = acc_q[2*XLEN-1:XLEN-1];
        div_ge     = (div_part >= {1'b0, opnd_q});
        div_rem_nx = div_ge ? XLEN'(div_part - {1'b0, opnd_q}) : div_part[XLEN-1:0];
        last_step  = (cnt_q == CNT_W'(ITER_CNT - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    op_d    = req.op;
                    neg_a_d = req_neg_a;
                    neg_b_d = req_neg_b;
                    if (req.op[2]) begin
                        opnd_d  = req_abs_b;
                        acc_d   = {{XLEN{1'b0}}, req_abs_a};
                        state_d = ST_DIV;
                    end else begin
                        opnd_d  = req_abs_a;
                        acc_d   = {{XLEN{1'b0}}, req_abs_b};
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) state_d = ST_FIX;
            end
            ST_DIV: begin
                acc_d = {div_rem_nx, acc_q[XLEN-2:0], div_ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end

    // Sign correction and word select, valid only while in FIX
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? (2*XLEN)'(-acc_q) : acc_q;
        quo  = abs_val(acc_q[XLEN-1:0], neg_a_q ^ neg_b_q);
        rem  = abs_val(acc_q[2*XLEN-1:XLEN], neg_a_q);
        if (op_q[2])
            result_c = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 2'b00)
            result_c = prod[XLEN-1:0];
        else
            result_c = prod[2*XLEN-1:XLEN];
    end

    assign busy   = (state_q != ST_IDLE);
    assign done_c = (state_q == ST_FIX);

endmodule

// File: rtl/alu_muldiv.sv
// Execution unit: 1-cycle RV32I datapath plus iterative RV32M engine, one result broadcast per cycle.
module alu_muldiv
    import alu_muldiv_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic need_flush_in,
    alu_muldiv_if.slave bus
);

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  value_q, value_d;
    logic [ROB_W-1:0] dep_q, dep_d;
    logic [ROB_W-1:0] m_rob_q, m_rob_d;

    logic             eng_busy, eng_done, eng_start;
    logic [XLEN-1:0]  eng_result;
    md_req_t          eng_req;

    logic             accept;
    logic             div_zero, div_ovf, special;
    logic [XLEN-1:0]  base_res, special_res;
    logic [XLEN-1:0]  a, b;
    logic [4:0]       shamt;

    assign a     = bus.rs2alu_opr1;
    assign b     = bus.rs2alu_opr2;
    assign shamt = b[4:0];

    always_comb begin
        unique case (bus.rs2alu_op_L1)
            OP_ADD:  base_res = bus.rs2alu_op_L2 ? (a - b) : (a + b);
            OP_SLL:  base_res = a << shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  base_res = a ^ b;
            OP_SR:   base_res = bus.rs2alu_op_L2 ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
            OP_OR:   base_res = a | b;
            OP_AND:  base_res = a & b;
            default: base_res = '0;
        endcase
    end

    // Divide-by-zero and signed overflow resolve without the engine
    always_comb begin
        div_zero    = (b == '0);
        div_ovf     = ~bus.rs2alu_op_L1[0] && (a == 32'h8000_0000) && (b == '1);
        special     = bus.rs2alu_mext & bus.rs2alu_op_L1[2] & (div_zero | div_ovf);
        special_res = div_zero ? (bus.rs2alu_op_L1[1] ? a : '1)
                               : (bus.rs2alu_op_L1[1] ? '0 : 32'h8000_0000);
    end

    assign accept    = bus.rs2alu_ready & ~eng_busy & ~need_flush_in;
    assign eng_start = accept & bus.rs2alu_mext & ~special;
    assign eng_req   = '{op: bus.rs2alu_op_L1, opr1: a, opr2: b};

    alu_muldiv_iter u_iter (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .en       (rdy_in),
        .flush    (need_flush_in),
        .start    (eng_start),
        .req      (eng_req),
        .busy     (eng_busy),
        .done_c   (eng_done),
        .result_c (eng_result)
    );

    always_comb begin
        valid_d = 1'b0;
        value_d = value_q;
        dep_d   = dep_q;
        m_rob_d = m_rob_q;
        if (eng_start) m_rob_d = bus.rs2alu_rob_id;
        if (need_flush_in) begin
            valid_d = 1'b0;
        end else if (eng_done) begin
            valid_d = 1'b1;
            value_d = eng_result;
            dep_d   = m_rob_q;
        end else if (accept && (!bus.rs2alu_mext || special)) begin
            valid_d = 1'b1;
            value_d = bus.rs2alu_mext ? special_res : base_res;
            dep_d   = bus.rs2alu_rob_id;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= 1'b0;
            value_q <= '0;
            dep_q   <= '0;
            m_rob_q <= '0;
        end else if (rdy_in) begin
            valid_q <= valid_d;
            value_q <= value_d;
            dep_q   <= dep_d;
            m_rob_q <= m_rob_d;
        end
    end

    assign bus.alu_valid      = valid_q;
    assign bus.alu_value      = value_q;
    assign bus.alu_dependency = dep_q;
    assign bus.alu_busy_out   = eng_busy;

endmodule
